// File: rtl/shift_pkg.sv
// Shared op-code, state and sizing definitions for the multi-cycle shift engine.
// Holds no logic, so it adds no latency and has no flow control of its own.
package shift_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 4;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result bundle between the operand logic and the shift sequencer.
// There is no backpressure: the requester watches busy/done before it raises start again.
interface shift_sequencer_if
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
);
    logic             start;
    logic [1:0]       op;
    logic [CNT_W-1:0] amount;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;

    modport master (
        output start, op, amount, din,
        input  busy, done, dout
    );

    modport slave (
        input  start, op, amount, din,
        output busy, done, dout
    );
endinterface

// File: rtl/shift_sequencer_shifter.sv
// Combinational single-step shifter (pass, LSL1, LSR1, ASR1); zero latency.
// Purely combinational, so it has no flow control.
module shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [1:0]       shift,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] sout
);

    always_comb begin
        sout = in;
        case (shift)
            SH_NONE: sout = in;
            SH_LSL:  sout = {in[WIDTH-2:0], 1'b0};
            SH_LSR:  sout = {1'b0, in[WIDTH-1:1]};
            SH_ASR:  sout = {in[WIDTH-1], in[WIDTH-1:1]};
            default: sout = in;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Variable shift built from one single-bit step per clock; done pulses amount+1 cycles after accept.
// start is taken only in IDLE or DONE and dropped while busy, with no queueing.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_sequencer_if.slave  bus
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       op_r, op_nxt;
    logic [WIDTH-1:0] dout_r, dout_nxt;
    logic [WIDTH-1:0] step;

    shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .shift (op_r),
        .in    (acc),
        .sout  (step)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            acc    <= '0;
            cnt    <= '0;
            op_r   <= SH_NONE;
            dout_r <= '0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            cnt    <= cnt_nxt;
            op_r   <= op_nxt;
            dout_r <= dout_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        op_nxt    = op_r;
        dout_nxt  = dout_r;

        case (state)
            ST_SHIFT: begin
                acc_nxt = step;
                cnt_nxt = cnt - CNT_W'(1);
                // Exit on the last step so the counter never wraps, even for the maximum amount.
                if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_DONE;
                    dout_nxt  = step;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (bus.start && (state == ST_IDLE || state == ST_DONE)) begin
            acc_nxt = bus.din;
            op_nxt  = bus.op;
            cnt_nxt = bus.amount;
            if (bus.amount == '0 || bus.op == SH_NONE) begin
                state_nxt = ST_DONE;
                dout_nxt  = bus.din;
            end else begin
                state_nxt = ST_SHIFT;
            end
        end
    end

    assign bus.busy = (state == ST_SHIFT);
    assign bus.done = (state == ST_DONE);
    assign bus.dout = dout_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed vector bench for shift_sequencer plus hand sequences for reset, ignore and back-to-back cases.
module tb_shift_sequencer;
    import shift_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    shift_sequencer_if #(.WIDTH(16), .CNT_W(4)) bus ();

    shift_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  amount;
        logic [15:0] din;
        logic [15:0] exp_dout;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Presents a request for one edge, then scrambles the inputs (they are don't-care afterwards).
    task automatic issue(input logic [1:0] o, input logic [3:0] a, input logic [15:0] d);
        bus.start  = 1'b1;
        bus.op     = o;
        bus.amount = a;
        bus.din    = d;
        tick();
        bus.start  = 1'b0;
        bus.op     = ~o;
        bus.amount = ~a;
        bus.din    = 16'hDEAD;
    endtask

    // Cycle 1 is the sample right after the accepting edge; returns -1 if done never rises.
    task automatic wait_done(input int max, input logic [15:0] prev, output int cyc,
                             output int busy_n, output int overlap, output int early);
        cyc = -1; busy_n = 0; overlap = 0; early = 0;
        for (int i = 1; i <= max; i++) begin
            if (i > 1) tick();
            if (bus.busy) busy_n++;
            if (bus.busy && bus.done) overlap++;
            if (bus.done) begin
                cyc = i;
                break;
            end
            if (bus.dout !== prev) early++;
        end
    endtask

    initial begin
        int          cyc, busy_n, overlap, early, dones;
        logic [15:0] prev, got;

        vecs[0]  = '{SH_LSL,  4'd15, 16'h0001, 16'h8000, 16};
        vecs[1]  = '{SH_LSR,  4'd4,  16'h8000, 16'h0800, 5};
        vecs[2]  = '{SH_ASR,  4'd4,  16'h8000, 16'hF800, 5};
        vecs[3]  = '{SH_LSL,  4'd0,  16'hA5A5, 16'hA5A5, 1};
        vecs[4]  = '{SH_NONE, 4'd9,  16'h5A3C, 16'h5A3C, 1};
        vecs[5]  = '{SH_LSR,  4'd4,  16'h00F0, 16'h000F, 5};
        vecs[6]  = '{SH_ASR,  4'd4,  16'h7FF0, 16'h07FF, 5};
        vecs[7]  = '{SH_LSL,  4'd8,  16'h00F0, 16'hF000, 9};
        vecs[8]  = '{SH_ASR,  4'd15, 16'h8001, 16'hFFFF, 16};
        vecs[9]  = '{SH_LSL,  4'd1,  16'hFFFF, 16'hFFFE, 2};
        vecs[10] = '{SH_LSR,  4'd1,  16'h0001, 16'h0000, 2};

        bus.start = 1'b0; bus.op = SH_NONE; bus.amount = '0; bus.din = '0;
        rst_n = 1'b0;
        tick(); tick();
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_dout", 32'(bus.dout), 32'h0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 11; v++) begin
            prev = bus.dout;
            issue(vecs[v].op, vecs[v].amount, vecs[v].din);
            wait_done(24, prev, cyc, busy_n, overlap, early);
            chk($sformatf("v%0d_done_cycle", v), 32'(cyc), 32'(vecs[v].exp_cyc));
            chk($sformatf("v%0d_dout", v), 32'(bus.dout), 32'(vecs[v].exp_dout));
            chk($sformatf("v%0d_busy_cycles", v), 32'(busy_n), 32'(vecs[v].exp_cyc - 1));
            chk($sformatf("v%0d_busy_done_overlap", v), 32'(overlap), 32'd0);
            chk($sformatf("v%0d_dout_early_change", v), 32'(early), 32'd0);
            tick();
            chk($sformatf("v%0d_done_single", v), 32'(bus.done), 32'd0);
            chk($sformatf("v%0d_dout_held", v), 32'(bus.dout), 32'(vecs[v].exp_dout));
            tick();
        end

        // Second request while shifting must be dropped.
        issue(SH_LSL, 4'd4, 16'h0001);
        bus.start = 1'b1; bus.op = SH_LSR; bus.amount = 4'd1; bus.din = 16'h1234;
        tick();
        bus.start = 1'b0;
        dones = 0; got = 16'hXXXX;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) begin
                dones++;
                got = bus.dout;
            end
            tick();
        end
        chk("ignore_done_count", 32'(dones), 32'd1);
        chk("ignore_dout", 32'(got), 32'h0010);

        // Back-to-back: start held in the DONE cycle.
        prev = bus.dout;
        issue(SH_LSR, 4'd4, 16'h8000);
        wait_done(24, prev, cyc, busy_n, overlap, early);
        chk("b2b_first_cycle", 32'(cyc), 32'd5);
        chk("b2b_first_dout", 32'(bus.dout), 32'h0800);
        issue(SH_LSL, 4'd2, 16'h0003);
        wait_done(24, 16'h0800, cyc, busy_n, overlap, early);
        chk("b2b_gap", 32'(cyc), 32'd3);
        chk("b2b_second_dout", 32'(bus.dout), 32'h000C);
        chk("b2b_dout_early_change", 32'(early), 32'd0);
        tick();

        // Reset in the middle of a shift discards it.
        issue(SH_LSL, 4'd8, 16'h00F0);
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_dout", 32'(bus.dout), 32'h0);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done) dones++;
        end
        chk("midrst_no_done", 32'(dones), 32'd0);
        chk("midrst_dout_after", 32'(bus.dout), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
